// File: rtl/walksat_select_seq.sv
// WalkSAT flip-variable selector: scans NSAT candidates one per cycle and picks the literal to flip.
// Optional macro HS_TIE_RANDOM_EN: greedy ties go to the first minimum in scan order instead of the highest index.
module walksat_select_seq #(
    parameter int unsigned NSAT = 3,
    parameter int unsigned BV_W = 5,
    parameter logic [31:0] P    = 32'h6E147AE0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [NSAT*BV_W-1:0]   break_values_i,
    input  logic [NSAT-1:0]        break_values_valid_i,
    input  logic [31:0]            random_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [$clog2(NSAT)-1:0] select_o,
    output logic                   random_selection_o,
    output logic                   none_valid_o
);

    localparam int unsigned SEL_W = $clog2(NSAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [NSAT*BV_W-1:0] bv;
    logic [NSAT-1:0]      valid;
    logic                 rw;
    logic [SEL_W-1:0]     idx;
    logic [SEL_W-1:0]     step;
    logic [1:0]           num_valid;
    logic                 has_zero;
    logic [SEL_W-1:0]     zero_idx;
    logic [SEL_W-1:0]     first_idx;
    logic [BV_W-1:0]      min_bv;
    logic [SEL_W-1:0]     min_idx;
    logic [SEL_W-1:0]     select;
    logic                 random_selection;
    logic                 none_valid;

    // Values derived from the current scan step
    logic [SEL_W-1:0]     start_idx;
    logic                 walk;
    logic [BV_W-1:0]      cand_bv;
    logic                 cand_valid;
    logic                 last_step;
    logic [SEL_W-1:0]     idx_next;
    logic                 tie_take;
    logic [1:0]           num_valid_upd;
    logic                 has_zero_upd;
    logic [SEL_W-1:0]     zero_idx_upd;
    logic [SEL_W-1:0]     first_idx_upd;
    logic [BV_W-1:0]      min_bv_upd;
    logic [SEL_W-1:0]     min_idx_upd;
    logic [SEL_W-1:0]     select_res;
    logic                 random_res;
    logic                 none_res;

    assign start_idx = SEL_W'(random_i[15:0] % 16'(NSAT));
    assign walk      = random_i > P;
    assign last_step = step == SEL_W'(NSAT - 1);
    assign idx_next  = (idx == SEL_W'(NSAT - 1)) ? '0 : idx + SEL_W'(1);

    always_comb begin
        cand_bv = '0;
        for (int unsigned k = 0; k < NSAT; k++) begin
            if (idx == SEL_W'(k)) begin
                cand_bv = bv[k*BV_W +: BV_W];
            end
        end
        cand_valid = valid[idx];
    end

`ifdef HS_TIE_RANDOM_EN
    assign tie_take = 1'b0;
`else
    assign tie_take = idx > min_idx;
`endif

    always_comb begin
        num_valid_upd = num_valid;
        has_zero_upd  = has_zero;
        zero_idx_upd  = zero_idx;
        first_idx_upd = first_idx;
        min_bv_upd    = min_bv;
        min_idx_upd   = min_idx;
        if (cand_valid) begin
            num_valid_upd = (num_valid == 2'd2) ? 2'd2 : num_valid + 2'd1;
            if (cand_bv == '0 && (!has_zero || idx > zero_idx)) begin
                has_zero_upd = 1'b1;
                zero_idx_upd = idx;
            end
            if (num_valid == 2'd0) begin
                first_idx_upd = idx;
            end
            if (num_valid == 2'd0 || cand_bv < min_bv || (cand_bv == min_bv && tie_take)) begin
                min_bv_upd  = cand_bv;
                min_idx_upd = idx;
            end
        end
    end

    // Result is resolved from the running state including the final step
    always_comb begin
        select_res = '0;
        random_res = 1'b0;
        none_res   = 1'b0;
        if (num_valid_upd == 2'd0) begin
            none_res = 1'b1;
        end else if (has_zero_upd) begin
            select_res = zero_idx_upd;
        end else if (num_valid_upd == 2'd1) begin
            select_res = first_idx_upd;
        end else if (rw) begin
            select_res = first_idx_upd;
            random_res = 1'b1;
        end else begin
            select_res = min_idx_upd;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid_i) state_next = SCAN;
            SCAN: if (last_step) state_next = DONE;
            DONE: if (out_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_i) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            bv               <= '0;
            valid            <= '0;
            rw               <= 1'b0;
            idx              <= '0;
            step             <= '0;
            num_valid        <= '0;
            has_zero         <= 1'b0;
            zero_idx         <= '0;
            first_idx        <= '0;
            min_bv           <= '0;
            min_idx          <= '0;
            select           <= '0;
            random_selection <= 1'b0;
            none_valid       <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid_i && !flush_i) begin
                        bv        <= break_values_i;
                        valid     <= break_values_valid_i;
                        rw        <= walk;
                        idx       <= start_idx;
                        step      <= '0;
                        num_valid <= '0;
                        has_zero  <= 1'b0;
                        zero_idx  <= '0;
                        first_idx <= '0;
                        min_bv    <= '0;
                        min_idx   <= '0;
                    end
                end
                SCAN: begin
                    num_valid <= num_valid_upd;
                    has_zero  <= has_zero_upd;
                    zero_idx  <= zero_idx_upd;
                    first_idx <= first_idx_upd;
                    min_bv    <= min_bv_upd;
                    min_idx   <= min_idx_upd;
                    idx       <= idx_next;
                    step      <= step + SEL_W'(1);
                    if (last_step) begin
                        select           <= select_res;
                        random_selection <= random_res;
                        none_valid       <= none_res;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        select           <= '0;
                        random_selection <= 1'b0;
                        none_valid       <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (flush_i) begin
                select           <= '0;
                random_selection <= 1'b0;
                none_valid       <= 1'b0;
            end
        end
    end

    assign in_ready_o         = state == IDLE;
    assign out_valid_o        = state == DONE;
    assign select_o           = select;
    assign random_selection_o = random_selection;
    assign none_valid_o       = none_valid;

endmodule

// File: tb/tb_walksat_select_seq.sv
// Directed table-driven bench for walksat_select_seq with NSAT=3 and NSAT=5 instances.
module tb_walksat_select_seq;

    typedef struct {
        int          nsat;
        logic [24:0] bv;
        logic [4:0]  valid;
        logic [31:0] rnd;
        logic [2:0]  sel;
        logic        rs;
        logic        none;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        flush3 = 1'b0, inv3 = 1'b0, outr3 = 1'b0;
    logic        inr3, outv3, rs3, nv3;
    logic [14:0] bvi3 = '0;
    logic [2:0]  val3 = '0;
    logic [31:0] rnd3 = '0;
    logic [1:0]  sel3;

    logic        flush5 = 1'b0, inv5 = 1'b0, outr5 = 1'b0;
    logic        inr5, outv5, rs5, nv5;
    logic [24:0] bvi5 = '0;
    logic [4:0]  val5 = '0;
    logic [31:0] rnd5 = '0;
    logic [2:0]  sel5;

    walksat_select_seq #(.NSAT(3), .BV_W(5), .P(32'h6E147AE0)) dut3 (
        .clk(clk), .reset(reset), .flush_i(flush3), .in_valid_i(inv3), .in_ready_o(inr3),
        .break_values_i(bvi3), .break_values_valid_i(val3), .random_i(rnd3),
        .out_valid_o(outv3), .out_ready_i(outr3), .select_o(sel3),
        .random_selection_o(rs3), .none_valid_o(nv3)
    );

    walksat_select_seq #(.NSAT(5), .BV_W(5), .P(32'h6E147AE0)) dut5 (
        .clk(clk), .reset(reset), .flush_i(flush5), .in_valid_i(inv5), .in_ready_o(inr5),
        .break_values_i(bvi5), .break_values_valid_i(val5), .random_i(rnd5),
        .out_valid_o(outv5), .out_ready_i(outr5), .select_o(sel5),
        .random_selection_o(rs5), .none_valid_o(nv5)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [24:0] pack3(input int a2, input int a1, input int a0);
        return {10'b0, 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    function automatic logic [24:0] pack5(input int a4, input int a3, input int a2, input int a1, input int a0);
        return {5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    function automatic logic o_valid(input int n); return (n == 3) ? outv3 : outv5; endfunction
    function automatic logic o_ready(input int n); return (n == 3) ? inr3 : inr5; endfunction
    function automatic logic [2:0] o_sel(input int n); return (n == 3) ? {1'b0, sel3} : sel5; endfunction
    function automatic logic o_rs(input int n); return (n == 3) ? rs3 : rs5; endfunction
    function automatic logic o_none(input int n); return (n == 3) ? nv3 : nv5; endfunction

    task automatic drive(input vec_t v, input logic in_valid);
        if (v.nsat == 3) begin
            inv3 = in_valid; bvi3 = v.bv[14:0]; val3 = v.valid[2:0]; rnd3 = v.rnd;
        end else begin
            inv5 = in_valid; bvi5 = v.bv; val5 = v.valid; rnd5 = v.rnd;
        end
    endtask

    task automatic set_out_ready(input int n, input logic r);
        if (n == 3) outr3 = r; else outr5 = r;
    endtask

    // Called at the negedge just after the accept edge; waits for the result and checks it.
    task automatic wait_result(input vec_t v, input string tag);
        int cyc = 1;
        while (!o_valid(v.nsat) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, v.nsat + 1);
        check({tag, "_select"}, o_sel(v.nsat), v.sel);
        check({tag, "_rand_sel"}, o_rs(v.nsat), v.rs);
        check({tag, "_none_valid"}, o_none(v.nsat), v.none);
    endtask

    task automatic release_result(input int n, input string tag);
        set_out_ready(n, 1'b1);
        @(negedge clk);
        check({tag, "_out_valid_cleared"}, o_valid(n), 0);
        check({tag, "_in_ready_back"}, o_ready(n), 1);
        set_out_ready(n, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive(v, 1'b1);
        check({tag, "_in_ready"}, o_ready(v.nsat), 1);
        @(negedge clk);
        drive(v, 1'b0);
        wait_result(v, tag);
        release_result(v.nsat, tag);
    endtask

    vec_t vt[14];
    int   n_vec;

    initial begin
        logic [2:0] e_tie2, e_tie3, e_tie5;
        int pulses;
`ifdef HS_TIE_RANDOM_EN
        e_tie2 = 3'd0; e_tie3 = 3'd1; e_tie5 = 3'd1;
`else
        e_tie2 = 3'd2; e_tie3 = 3'd2; e_tie5 = 3'd3;
`endif
        vt[0]  = '{3, pack3(7, 0, 0),    5'b00111, 32'h00000000, 3'd1, 1'b0, 1'b0};
        vt[1]  = '{3, pack3(4, 9, 4),    5'b00111, 32'h00000000, e_tie2, 1'b0, 1'b0};
        vt[2]  = '{3, pack3(6, 5, 3),    5'b00101, 32'hFFFF0001, 3'd2, 1'b1, 1'b0};
        vt[3]  = '{3, pack3(1, 2, 3),    5'b00000, 32'hFFFFFFFF, 3'd0, 1'b0, 1'b1};
        vt[4]  = '{3, pack3(0, 9, 0),    5'b00010, 32'hFFFFFFFF, 3'd1, 1'b0, 1'b0};
        vt[5]  = '{3, pack3(3, 3, 3),    5'b00111, 32'h00000001, e_tie3, 1'b0, 1'b0};
        vt[6]  = '{3, pack3(31, 30, 31), 5'b00111, 32'h00000000, 3'd1, 1'b0, 1'b0};
        vt[7]  = '{3, pack3(5, 6, 7),    5'b00011, 32'hFFFF0002, 3'd0, 1'b1, 1'b0};
        vt[8]  = '{3, pack3(0, 4, 0),    5'b00101, 32'hFFFFFFFF, 3'd2, 1'b0, 1'b0};
        vt[9]  = '{3, pack3(5, 6, 7),    5'b00111, 32'h6E147AE0, 3'd2, 1'b0, 1'b0};
        vt[10] = '{3, pack3(5, 6, 7),    5'b00111, 32'h6E147AE1, 3'd2, 1'b1, 1'b0};
        vt[11] = '{5, pack5(7, 7, 7, 0, 0), 5'b11111, 32'h00000000, 3'd1, 1'b0, 1'b0};
        vt[12] = '{5, pack5(6, 6, 6, 5, 3), 5'b11101, 32'hFFFF0001, 3'd2, 1'b1, 1'b0};
        vt[13] = '{5, pack5(9, 2, 8, 2, 5), 5'b11111, 32'h00000000, e_tie5, 1'b0, 1'b0};
        n_vec = 14;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_in_ready3", inr3, 1);
        check("reset_out_valid3", outv3, 0);
        check("reset_outputs3", {sel3, rs3, nv3}, 0);
        check("reset_in_ready5", inr5, 1);
        check("reset_outputs5", {outv5, sel5, rs5, nv5}, 0);

        for (int i = 0; i < n_vec; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        // NSAT=5 wrap from index 4 to 0 under a random walk
        run_vec('{5, pack5(1, 1, 1, 1, 1), 5'b00011, 32'hFFFF0004, 3'd0, 1'b1, 1'b0}, "vec5_wrap");

        // Back-pressure in DONE, then a new item right after release
        @(negedge clk);
        drive(vt[0], 1'b1);
        @(negedge clk);
        drive(vt[0], 1'b0);
        wait_result(vt[0], "stall_first");
        drive(vt[2], 1'b1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_out_valid_%0d", i), outv3, 1);
            check($sformatf("stall_select_%0d", i), {sel3, rs3, nv3}, {2'd1, 1'b0, 1'b0});
            check($sformatf("stall_in_ready_%0d", i), inr3, 0);
            @(negedge clk);
        end
        outr3 = 1'b1;
        @(negedge clk);
        outr3 = 1'b0;
        check("stall_release_in_ready", inr3, 1);
        check("stall_release_out_valid", outv3, 0);
        check("stall_release_cleared", {sel3, rs3, nv3}, 0);
        @(negedge clk);
        drive(vt[2], 1'b0);
        wait_result(vt[2], "stall_second");
        release_result(3, "stall_second");

        // Flush in the second SCAN cycle drops the item
        @(negedge clk);
        drive(vt[0], 1'b1);
        @(negedge clk);
        drive(vt[0], 1'b0);
        @(negedge clk);
        flush3 = 1'b1;
        @(negedge clk);
        flush3 = 1'b0;
        check("flush_in_ready", inr3, 1);
        check("flush_out_valid", outv3, 0);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (outv3) pulses++;
        end
        check("flush_no_pulse", pulses, 0);

        // Flush together with in_valid: no accept
        drive(vt[0], 1'b1);
        flush3 = 1'b1;
        @(negedge clk);
        flush3 = 1'b0;
        drive(vt[0], 1'b0);
        check("flush_beats_valid_in_ready", inr3, 1);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (outv3) pulses++;
        end
        check("flush_beats_valid_no_pulse", pulses, 0);

        // Flush beats out_ready in DONE
        @(negedge clk);
        drive(vt[2], 1'b1);
        @(negedge clk);
        drive(vt[2], 1'b0);
        wait_result(vt[2], "flush_done");
        flush3 = 1'b1;
        outr3 = 1'b1;
        @(negedge clk);
        flush3 = 1'b0;
        outr3 = 1'b0;
        check("flush_done_out_valid", outv3, 0);
        check("flush_done_in_ready", inr3, 1);

        // Reset (with flush also high) while in DONE
        @(negedge clk);
        drive(vt[2], 1'b1);
        @(negedge clk);
        drive(vt[2], 1'b0);
        wait_result(vt[2], "reset_done");
        reset = 1'b1;
        flush3 = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        flush3 = 1'b0;
        check("reset_done_out_valid", outv3, 0);
        check("reset_done_in_ready", inr3, 1);
        check("reset_done_outputs", {sel3, rs3, nv3}, 0);
        run_vec(vt[0], "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
